// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-wide memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_RD_D,
    ST_RD_I,
    ST_DONE
  } state_t;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_WB = 2'd0;
  localparam gnt_t GNT_D  = 2'd1;
  localparam gnt_t GNT_I  = 2'd2;

endpackage

// File: rtl/mem_arbiter_wb_buffer.sv
// One-entry write-back buffer: captures a pulse when empty, flags overflow when full.
module wb_buffer #(
  parameter int ADDR_W = 10,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              rel,
  output logic              full,
  output logic              ready,
  output logic              ovf,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] line
);

  logic full_nxt;

  always_comb begin
    full_nxt = full;
    if (rel)
      full_nxt = 1'b0;
    if (wr_en && !full)
      full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full  <= 1'b0;
      ready <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      full  <= full_nxt;
      ready <= !full_nxt;
      if (wr_en && full)
        ovf <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      addr <= wr_addr;
      line <= wr_line;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fill, D-fill and D write-back traffic onto one request/ack memory port.
// Build option: define MEM_ARB_RR_EN for round-robin between tied fill requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ic_mem_req,
  input  logic [ADDR_W-1:0] Ic_mem_addr,
  output logic [LINE_W-1:0] F_mem_inst,
  output logic              F_mem_valid,
  input  logic              Dc_mem_req,
  input  logic [ADDR_W-1:0] Dc_mem_addr,
  output logic [LINE_W-1:0] MEM_data_line,
  output logic              MEM_mem_valid,
  input  logic              Dc_wb_we,
  input  logic [ADDR_W-1:0] Dc_wb_addr,
  input  logic [LINE_W-1:0] Dc_wb_wline,
  output logic              Dc_wb_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic [LINE_W-1:0] mem_rline,
  input  logic              mem_valid,
  output logic              err_wb_ovf
);

  state_t            state, state_nxt;
  gnt_t              gnt_q, gnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              pick_i;
  logic              wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_line;

  wb_buffer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_wb_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (Dc_wb_we),
    .wr_addr (Dc_wb_addr),
    .wr_line (Dc_wb_wline),
    .rel     (state == ST_WB && mem_valid),
    .full    (wb_full),
    .ready   (Dc_wb_ready),
    .ovf     (err_wb_ovf),
    .addr    (wb_addr),
    .line    (wb_line)
  );

`ifdef MEM_ARB_RR_EN
  gnt_t last_fill;

  // On a tie, the port that was not served last goes next.
  assign pick_i = Ic_mem_req && (!Dc_mem_req || last_fill == GNT_D);

  always_ff @(posedge clk) begin
    if (!rst)
      last_fill <= GNT_D;
    else if (state == ST_IDLE && (state_nxt == ST_RD_D || state_nxt == ST_RD_I))
      last_fill <= gnt_nxt;
  end
`else
  assign pick_i = Ic_mem_req && !Dc_mem_req;
`endif

  // A write-back arriving this cycle outranks fills so a same-line fill sees fresh data.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    case (state)
      ST_IDLE: begin
        if (wb_full || Dc_wb_we) begin
          state_nxt = ST_WB;
          gnt_nxt   = GNT_WB;
        end else if (pick_i) begin
          state_nxt = ST_RD_I;
          gnt_nxt   = GNT_I;
        end else if (Dc_mem_req) begin
          state_nxt = ST_RD_D;
          gnt_nxt   = GNT_D;
        end
      end
      ST_WB:            if (mem_valid) state_nxt = ST_IDLE;
      ST_RD_D, ST_RD_I: if (mem_valid) state_nxt = ST_DONE;
      ST_DONE:          state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      gnt_q         <= GNT_WB;
      F_mem_inst    <= '0;
      MEM_data_line <= '0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      if (state == ST_RD_I && mem_valid)
        F_mem_inst <= mem_rline;
      if (state == ST_RD_D && mem_valid)
        MEM_data_line <= mem_rline;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && state_nxt == ST_RD_D)
      addr_q <= Dc_mem_addr;
    else if (state == ST_IDLE && state_nxt == ST_RD_I)
      addr_q <= Ic_mem_addr;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wline = '0;
    case (state)
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_addr;
        mem_wline = wb_line;
      end
      ST_RD_D, ST_RD_I: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      default: ;
    endcase
  end

  assign F_mem_valid   = (state == ST_DONE) && (gnt_q == GNT_I);
  assign MEM_mem_valid = (state == ST_DONE) && (gnt_q == GNT_D);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one line-wide backing memory between I-cache line fills, D-cache line fills and D-cache line write-backs.
- Sits directly downstream of icache_simple and dcache, in place of the separate instruct_mem and data_mem ports.
- Keeps each cache's existing request/valid protocol unchanged and serialises traffic onto a single request/acknowledge memory port.
- Write-backs go through a one-entry buffer.

Parameters:
- ADDR_W, 10, line address width.
- LINE_W, 128, line width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low; state is cleared on a clk edge where rst=0.
- Ic_mem_req  in  1  I-cache fill request, level.
- Ic_mem_addr  in  ADDR_W  I-cache fill line address.
- F_mem_inst  out  LINE_W  fill data returned to the I-cache.
- F_mem_valid  out  1  one-cycle pulse: F_mem_inst is valid.
- Dc_mem_req  in  1  D-cache fill request, level.
- Dc_mem_addr  in  ADDR_W  D-cache fill line address.
- MEM_data_line  out  LINE_W  fill data returned to the D-cache.
- MEM_mem_valid  out  1  one-cycle pulse: MEM_data_line is valid.
- Dc_wb_we  in  1  one-cycle write-back pulse.
- Dc_wb_addr  in  ADDR_W  write-back line address.
- Dc_wb_wline  in  LINE_W  write-back line data.
- Dc_wb_ready  out  1  write-back buffer can accept a pulse.
- mem_req  out  1  backing memory request, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  out  ADDR_W  backing memory line address.
- mem_wline  out  LINE_W  backing memory write data.
- mem_rline  in  LINE_W  backing memory read data.
- mem_valid  in  1  one-cycle acknowledge; for reads, mem_rline is valid.
- err_wb_ovf  out  1  sticky: a write-back arrived while the buffer was full.

Behaviour:
- Reset state: IDLE. Write-back buffer empty.
- Reset values: every output 0, including Dc_wb_ready and err_wb_ovf. Dc_wb_ready rises the first cycle after rst returns to 1.
- States: IDLE, WB, RD_D, RD_I, DONE.
- IDLE grant, first match wins:
  - Buffer full, or Dc_wb_we=1 this cycle -> WB. An incoming write-back counts as pending, so a same-address fill never reads stale data.
  - Dc_mem_req -> RD_D.
  - Ic_mem_req -> RD_I.
  - Nothing pending -> stay IDLE.
- The granted address is latched on entry to RD_D/RD_I.
- WB, RD_D, RD_I drive the memory port:
  - mem_req=1; mem_addr/mem_we/mem_wline stable until mem_valid.
  - WB: mem_we=1, address and data from the buffer.
  - RD_D/RD_I: mem_we=0, latched address.
- On mem_valid:
  - WB: buffer empties; state -> IDLE.
  - RD_D: MEM_data_line <= mem_rline; state -> DONE.
  - RD_I: F_mem_inst <= mem_rline; state -> DONE.
- mem_req drops in the cycle after mem_valid.
- DONE: the selected valid is high for exactly one cycle, then -> IDLE.
  - Data outputs hold their value until the next fill for that port.
  - Requesters deassert req on the edge that samples valid.
  - Fill latency = memory latency + 1 cycle.
- Write-back buffer:
  - Captures Dc_wb_addr/Dc_wb_wline on a Dc_wb_we edge when empty.
  - Dc_wb_ready = !full, registered.
  - Dc_wb_we while full: pulse ignored, buffer contents unchanged, err_wb_ovf <= 1 until reset.
- mem_valid in IDLE or DONE is ignored; this covers a late acknowledge after reset.
- Reset mid-transaction: next state IDLE, mem_req=0, buffer cleared, no valid pulse.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a register records the last serviced fill port. When both fill requests are pending in IDLE (no write-back pending), the port not served last wins. Write-back priority is unchanged. The register resets to D, so I wins the first tie.
- Undefined: fixed D-over-I priority and no last-grant register.

Decomposition:
- Package mem_arb_pkg:
  - state enum for the five states;
  - ADDR_W and LINE_W defaults;
  - grant-source constants GNT_WB, GNT_D, GNT_I.
- Sub-module wb_buffer: one-entry valid/addr/data register with capture, release, ready and overflow detection.
- Everything else stays in mem_arbiter.

Test Plan:
- I fill only: Ic_mem_req, address 0x010; memory latency 2 returns 128'hA5…A5. Expected: mem_req with mem_addr=0x010 and mem_we=0; F_mem_valid pulses once, 1 cycle after mem_valid; F_mem_inst = 128'hA5…A5.
- Fill tie: Ic_mem_req and Dc_mem_req rise together.
  - Macro undefined: D served first, then I.
  - Macro defined, first tie after reset: I served first.
- Same-line ordering: Dc_wb_we for address 0x005 with data X in the same cycle Dc_mem_req for 0x005 rises. Expected: write issued first; MEM_data_line = X.
- Overflow: two Dc_wb_we pulses in consecutive cycles while memory is stalled. Expected: Dc_wb_ready=0 after the first; second pulse dropped; err_wb_ovf=1 and still 1 after 10 cycles; only the first line is written.
- Reset mid-read: rst=0 while in RD_I, then mem_valid arrives after rst returns to 1. Expected: mem_req=0 after the reset edge; F_mem_valid never pulses; state IDLE.
- Back-to-back fills: D fill, then I fill requested during DONE. Expected: I granted the cycle after DONE; no spurious second D grant.
